// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, read ports, scoreboard set
// port and the clear handshake. The master drives requests and the slave
// (the register file) returns read data, pending flags and busy.
interface reg_file_sb_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2
);
  logic              clr_req;
  logic              busy;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    pend;
  logic              set_en;
  logic [AW-1:0]     set_addr;

  modport master (
    output clr_req, we, wa, wd, ra, set_en, set_addr,
    input  busy, rd, pend
  );

  modport slave (
    input  clr_req, we, wa, wd, ra, set_en, set_addr,
    output busy, rd, pend
  );
endinterface

// File: rtl/reg_file_sb.sv
// Decode-stage register file with pending scoreboard and clear sequencer.
// NRD asynchronous read ports, one synchronous write port, a per-register
// pending bit for long-latency ops, and a sweep that zeroes the
// distributed-RAM array after reset or on clr_req.
// Optional feature: define REG_FILE_BYPASS_EN for write-first bypass of a
// same-cycle write onto the read ports; otherwise reads show array state.
// Module parameters must match those of the connected reg_file_sb_if.
module reg_file_sb #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic              r_busy;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;

  logic              w_wr;
  logic              w_set;
  logic              w_clr_start;
  logic [NRD*DW-1:0] w_rd;
  logic [NRD-1:0]    w_pend;

  // Register 0 is hardwired to zero, so writes and sets to it are dropped;
  // everything external is frozen while the sweep owns the array.
  assign w_wr        = bus.we     && (bus.wa       != '0) && !r_busy;
  assign w_set       = bus.set_en && (bus.set_addr != '0) && !r_busy;
  assign w_clr_start = (r_state == S_READY) && bus.clr_req;

  // Clear sequencer: walk ptr over every entry, then idle until clr_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == AW'(DEPTH - 1)) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        S_READY: begin
          if (bus.clr_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Single-write-port array with no reset so it maps to distributed RAM;
  // the sweep and the external write share the port, sweep first.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      r_mem[bus.wa] <= bus.wd;
    end
  end

  // Scoreboard: writeback retires a pending op, a new issue marks one;
  // the issue is applied last so it wins on a same-register collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (w_clr_start) begin
      r_pending <= '0;
    end else begin
      if (w_wr) begin
        r_pending[bus.wa] <= 1'b0;
      end
      if (w_set) begin
        r_pending[bus.set_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports with zero-register, busy and bypass handling.
  always_comb begin
    logic [AW-1:0] w_ra;
    w_rd   = '0;
    w_pend = '0;
    w_ra   = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra = bus.ra[i*AW +: AW];
      if (r_busy || (w_ra == '0)) begin
        w_rd[i*DW +: DW] = '0;
        w_pend[i]        = 1'b0;
`ifdef REG_FILE_BYPASS_EN
      end else if (w_wr && (bus.wa == w_ra)) begin
        w_rd[i*DW +: DW] = bus.wd;
        w_pend[i]        = 1'b0;
`endif
      end else begin
        w_rd[i*DW +: DW] = r_mem[w_ra];
        w_pend[i]        = r_pending[w_ra];
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.rd   = w_rd;
  assign bus.pend = w_pend;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb against a cycle-level behavioural
// model: a memory array, a pending array and a count of remaining sweep
// cycles. Follows REG_FILE_BYPASS_EN the same way the design does.
module tb_reg_file_sb;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) bus ();

  reg_file_sb #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pnd [DEPTH];
  int            m_left;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k] = '0;
      m_pnd[k] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] a;
    a = bus.ra[i*AW +: AW];
    if (m_left > 0 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we && bus.wa != 0 && bus.wa == a) return bus.wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_pd(input int i);
    logic [AW-1:0] a;
    a = bus.ra[i*AW +: AW];
    if (m_left > 0 || a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (bus.we && bus.wa != 0 && bus.wa == a) return 1'b0;
`endif
    return m_pnd[a];
  endfunction

  // Apply the rising edge to the model using the inputs held this cycle.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (bus.we && bus.wa != 0) begin
        m_mem[bus.wa] = bus.wd;
        m_pnd[bus.wa] = 1'b0;
      end
      if (bus.set_en && bus.set_addr != 0) m_pnd[bus.set_addr] = 1'b1;
      if (bus.clr_req) begin
        model_reset();
      end
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    if (!rst_n) model_reset();
    #4;
    check_eq("busy", 64'(bus.busy), 64'(m_left > 0));
    for (int i = 0; i < NRD; i++) begin
      check_eq($sformatf("rd%0d", i), 64'(bus.rd[i*DW +: DW]), 64'(exp_rd(i)));
      check_eq($sformatf("pend%0d", i), 64'(bus.pend[i]), 64'(exp_pd(i)));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.clr_req  = 1'b0;
    bus.we       = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.set_en   = 1'b0;
    bus.set_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(AW'(a), AW'(DEPTH - 1 - a));
      step();
    end
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
  endtask

  initial begin
    idle();
    set_ra('0, '0);
    model_reset();
    @(posedge clk);
    #1;

    // Reset held, then release: exactly DEPTH busy cycles, then all zero.
    step();
    step();
    rst_n = 1'b1;
    repeat (DEPTH) step();
    read_all();

    // Plain write and read-back; register 0 stays zero.
    write(5, 32'hDEADBEEF); set_ra(5, 0); step();
    idle();                 set_ra(5, 5); step();
    write(0, 32'h1234);     set_ra(0, 5); step();
    idle();                 set_ra(0, 0); step();

    // Same-cycle write and read of register 7.
    write(7, 32'h11111111); set_ra(1, 7); step();
    write(7, 32'hA5A5A5A5); set_ra(7, 7); step();
    idle();                 set_ra(7, 7); step();

    // Scoreboard set, retire by write, and set+write collision.
    idle(); bus.set_en = 1'b1; bus.set_addr = 3; set_ra(3, 3); step();
    idle();                                      set_ra(3, 0); step();
    write(3, 32'h33);                            set_ra(3, 3); step();
    idle();                                      set_ra(3, 3); step();
    write(3, 32'h44); bus.set_en = 1'b1; bus.set_addr = 3; step();
    idle();                                      set_ra(3, 3); step();
    bus.set_en = 1'b1; bus.set_addr = 0;         set_ra(0, 0); step();

    // Fill 1..4, clear sweep with dropped write/set and an ignored clr_req.
    for (int a = 1; a <= 4; a++) begin
      write(AW'(a), DW'(32'h100 + a)); set_ra(AW'(a), 3); step();
    end
    idle(); bus.set_en = 1'b1; bus.set_addr = 2; step();
    idle(); bus.clr_req = 1'b1; set_ra(2, 4); step();
    idle(); write(9, 32'h99); bus.set_en = 1'b1; bus.set_addr = 9; set_ra(9, 2); step();
    idle(); bus.clr_req = 1'b1; step();
    idle();
    repeat (DEPTH - 2) step();
    read_all();

    // Reset asserted ten cycles into a clr_req sweep.
    write(6, 32'h66); bus.set_en = 1'b1; bus.set_addr = 6; step();
    idle(); bus.clr_req = 1'b1; set_ra(6, 6); step();
    idle();
    repeat (10) step();
    rst_n = 1'b0; step();
    step();
    rst_n = 1'b1;
    repeat (DEPTH) step();
    read_all();

    // Randomized traffic, mostly on a small address window to force overlap.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] msk;
      msk = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1) : AW'(7);
      bus.we       = ($urandom_range(0, 1) == 1);
      bus.wa       = AW'($urandom) & msk;
      bus.wd       = DW'($urandom);
      bus.set_en   = ($urandom_range(0, 2) == 0);
      bus.set_addr = AW'($urandom) & msk;
      bus.clr_req  = ($urandom_range(0, 99) == 0);
      set_ra(AW'($urandom) & msk, AW'($urandom) & msk);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
